// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-fetch slice: instruction width, the
// canonical NOP, the sequential PC step and the fetch FSM state encodings.
package riscv_pkg;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0 -- what decode sees whenever no instruction is valid
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  // Byte distance between consecutive sequential fetches
  localparam int PC_INCR = 4;

  // Fetch FSM encodings, kept as plain constants so older tools can read them
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register with a one-entry hold buffer. A flush empties both the
// output and the buffer. A load that arrives while decode is stalled on a
// valid instruction is parked in the buffer and released once the stall drops.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_pc,
  input  logic [INSTR_W-1:0]  load_instr,
  input  logic                stall,
  input  logic                flush,
  output logic                if_valid,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [INSTR_W-1:0]  if_instr
);

  logic                hold_full;
  logic [ADDR_W-1:0]   hold_pc;
  logic [INSTR_W-1:0]  hold_instr;
  logic                blocked;

  assign blocked = if_valid & stall;

  // Output register and hold buffer: flush first, then drain the buffer, then accept new loads, then consume
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
      hold_full  <= 1'b0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else if (flush) begin
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      hold_full  <= 1'b0;
    end else if (hold_full) begin
      if (!stall) begin
        if_valid  <= 1'b1;
        if_pc     <= hold_pc;
        if_instr  <= hold_instr;
        hold_full <= 1'b0;
      end
    end else if (load) begin
      if (blocked) begin
        hold_pc    <= load_pc;
        hold_instr <= load_instr;
        hold_full  <= 1'b1;
      end else begin
        if_valid <= 1'b1;
        if_pc    <= load_pc;
        if_instr <= load_instr;
      end
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Drives the external PC register, issues one memory
// request per PC with at most one outstanding, and hands responses to decode
// through if_id_reg. Redirects from execute override everything and flush.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc_q,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_next,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INSTR_W-1:0]  imem_resp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic                if_valid,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [INSTR_W-1:0]  if_instr
);

  // RESET_PC documents what the external PC register comes out of reset with;
  // this stage never needs it because it always fetches from pc_q.

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic                drop;
  logic                drop_next;
  logic [ADDR_W-1:0]   req_pc;
  logic                req_fire;
  logic                resp_load;

  // Request side and PC register control; a redirect suppresses the request and wins the PC mux
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    pc_load        = 1'b0;
    pc_next        = pc_q + ADDR_W'(PC_INCR);
    if (!reset) begin
      imem_req_valid = (state == ST_FETCH) && !redirect_valid;
      if (redirect_valid) begin
        pc_load = 1'b1;
        pc_next = redirect_pc & ~ADDR_W'(3);
      end else if (imem_req_valid && imem_req_ready) begin
        pc_load = 1'b1;
      end
    end
  end

  assign req_fire = imem_req_valid & imem_req_ready;

  // Next-state logic; drop remembers that the response still in flight belongs to a squashed fetch
  always_comb begin
    state_next = state;
    drop_next  = drop;
    resp_load  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (req_fire) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_next = ST_FETCH;
          drop_next  = 1'b0;
          if (!redirect_valid && !drop) begin
            resp_load = 1'b1;
            if (if_valid && stall) state_next = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || !stall) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // FSM, drop flag and the PC of the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (req_fire) req_pc <= pc_q;
    end
  end

  if_id_reg #(
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (resp_load),
    .load_pc    (req_pc),
    .load_instr (imem_resp_data),
    .stall      (stall),
    .flush      (redirect_valid),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that drives the PC register's load/data inputs and consumes its Q output. It issues one instruction-memory request per fetched PC and tracks at most one outstanding request. It delivers {pc, instr, valid} to decode through a stall-aware output register. Branch/jump redirects from execute take priority and flush in-flight work.

Parameters:
ADDR_W, 32, PC / instruction-memory byte-address width; must match PC register N
RESET_PC, 0, PC value the PC register holds after reset; reference only, used by the bench
NOP_INSTR, 32'h00000013, value of if_instr whenever if_valid=0

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset
pc_q  in  ADDR_W  current PC from PC register
pc_load  out  1  load strobe to PC register
pc_next  out  ADDR_W  data to PC register
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request byte address
imem_resp_valid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance
imem_resp_data  in  32  fetched instruction
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  ADDR_W  redirect target
stall  in  1  decode cannot accept new if_* this cycle
if_valid  out  1  if_pc/if_instr valid
if_pc  out  ADDR_W  PC of delivered instruction
if_instr  out  32  delivered instruction

Behaviour:
- Reset: reset is synchronous, active-high, and applies to every register. Reset values: state=FETCH, drop=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR, hold buffer empty. Combinational outputs during reset: pc_load=0, imem_req_valid=0.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req_valid=1 and imem_req_addr=pc_q, except when redirect_valid=1.
  - On handshake (req_valid & req_ready): pc_load=1, pc_next=pc_q+4 (mod 2^ADDR_W); capture req_pc=pc_q; go to WAIT.
  - If req_ready=0: hold the request stable and stay in FETCH.
- WAIT:
  - imem_req_valid=0; wait for imem_resp_valid.
  - Response with drop=1: discard it, clear drop, go to FETCH.
  - Response when the output register can accept (if_valid=0 or stall=0): if_valid=1, if_pc=req_pc, if_instr=resp_data; go to FETCH.
  - Response when the output register is blocked (if_valid=1 and stall=1): capture into the hold buffer; go to HOLD.
- HOLD:
  - No requests issued.
  - When stall=0: move the hold buffer to if_*, set if_valid=1, go to FETCH.
- Output consumption: if_valid=1 and stall=0 with no new instruction loading → if_valid=0 and if_instr=NOP_INSTR next cycle.
- Latency: PC accepted at cycle t, response at t+k (k≥1) → if_valid at t+k+1 when not stalled. Peak throughput is one instruction per 2 cycles (FETCH→WAIT).
- Redirect (highest priority; overrides stall):
  - pc_load=1, pc_next={redirect_pc[ADDR_W-1:2],2'b00}. Low bits are forced to zero; no misalignment trap.
  - imem_req_valid is forced to 0 in that cycle.
  - Next cycle: if_valid=0, if_instr=NOP_INSTR, hold buffer cleared.
  - Redirect in FETCH: stay in FETCH.
  - Redirect in HOLD: go to FETCH.
  - Redirect in WAIT with no response that cycle: set drop=1, stay in WAIT.
  - Redirect in WAIT with a response the same cycle: discard the response, go to FETCH, drop stays 0.
- Simultaneous redirect and stall: redirect wins; the flush happens regardless of stall.
- pc_load and FETCH-state imem_req_valid are combinational from state and inputs. All if_* outputs are registered.
- Never more than one outstanding request. A response arriving outside WAIT is a protocol error; the bench asserts it never occurs.

Decomposition:
- Shared package riscv_pkg: INSTR_W=32, NOP_INSTR, fetch state enum (FETCH/WAIT/HOLD), PC increment constant 4.
- One natural sub-module: if_id_reg. It is the stall/flush output register plus the one-entry hold buffer (load, stall, flush inputs).
- fetch_unit contains the FSM, drop flag, req_pc, and pc_next mux.

Test Plan:
- Reset then free-running memory (ready=1, 1-cycle response), stall=0 → pc_next 0x4, 0x8, 0xC; if_pc 0x0, 0x4, 0x8 with data matching memory; if_valid pulses every 2 cycles.
- imem_req_ready=0 for 3 cycles in FETCH → imem_req_addr held at 0x8, pc_load=0, no if_valid change; on ready=1, pc_next=0xC.
- Stall=1 with if_valid=1 (if_pc=0x4) when the 0x8 response arrives → if_* stays 0x4, FSM enters HOLD, no new request; stall=0 → if_pc=0x8 next cycle, then a request to 0xC.
- Redirect to 0x40 while in WAIT, response 2 cycles later → that response discarded (if_valid stays 0), next request addr=0x40, then if_pc=0x40.
- Redirect to 0x83 in the same cycle as the response and stall=1 → pc_next=0x80, if_valid=0 next cycle, response not delivered, next request addr=0x80.
- ADDR_W=6, pc_q=0x3C accepted → pc_next=0x00 (wrap); if_pc=0x3C delivered correctly.
